// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_e;

  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned PKT_LEN_DEF   = 4;
  localparam int unsigned CNT_W_DEF     = 16;

  // Packet index needs at least one bit even when PKT_LEN is 1.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream, seen from the consumer (master) side.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 r_empty;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_inc;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;

  modport master (
    input  r_empty, r_data, m_ready,
    output r_inc, m_valid, m_data, m_last
  );

  modport slave (
    output r_empty, r_data, m_ready,
    input  r_inc, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry output buffer: push into the tail, pop from the head, head always visible.
module fifo_rd_stream_skid #(
  parameter int unsigned Width = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_word,
  input  logic             i_pop,
  output logic [1:0]       o_cnt,
  output logic [1:0]       o_cnt_next,
  output logic [Width-1:0] o_head
);

  logic [1:0]       r_cnt;
  logic [Width-1:0] r_head;
  logic [Width-1:0] r_tail;
  logic [1:0]       w_cnt_next;

  assign w_cnt_next = r_cnt + {1'b0, i_push} - {1'b0, i_pop};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      unique case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_push_word;
          else               r_tail <= i_push_word;
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          // With one entry the incoming word becomes the new head directly.
          if (r_cnt == 2'd1) begin
            r_head <= i_push_word;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt      = r_cnt;
  assign o_cnt_next = w_cnt_next;
  assign o_head     = r_head;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the dual-clock FIFO read port and presents words as a framed valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned PKT_LEN   = PKT_LEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                    r_clk,
  input  logic                    rrst_n,
  input  logic                    en,
  fifo_rd_stream_if.master        bus,
  output logic [CNT_W-1:0]        rd_count,
  output logic                    busy
);

  localparam int unsigned   IdxW    = idx_width(PKT_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_LEN - 1);

  rd_state_e        r_state;
  logic [IdxW-1:0]  r_pkt_idx;
  logic [CNT_W-1:0] r_rd_count;

  logic             w_pop;
  logic             w_fire;
  logic             w_last_tag;
  logic [1:0]       w_cnt;
  logic [1:0]       w_cnt_next;
  logic [DATA_SIZE:0] w_head;

  // Pop depends only on registered buffer state, never on m_ready.
  assign w_pop      = rrst_n & en & ~bus.r_empty & (w_cnt < 2'd2) & (r_state != DRAIN);
  assign w_fire     = bus.m_valid & bus.m_ready;
  assign w_last_tag = (r_pkt_idx == LastIdx);

  fifo_rd_stream_skid #(
    .Width(DATA_SIZE + 1)
  ) u_skid (
    .i_clk      (r_clk),
    .i_rst_n    (rrst_n),
    .i_push     (w_pop),
    .i_push_word({w_last_tag, bus.r_data}),
    .i_pop      (w_fire),
    .o_cnt      (w_cnt),
    .o_cnt_next (w_cnt_next),
    .o_head     (w_head)
  );

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      r_state    <= IDLE;
      r_pkt_idx  <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_pop) begin
        r_pkt_idx <= w_last_tag ? '0 : r_pkt_idx + IdxW'(1);
      end
      if (w_fire) begin
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
      unique case (r_state)
        IDLE: if (en) r_state <= RUN;
        RUN: begin
          if (!en) r_state <= (w_cnt_next != 2'd0) ? DRAIN : IDLE;
        end
        DRAIN: if (w_cnt_next == 2'd0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.r_inc   = w_pop;
  assign bus.m_valid = (w_cnt != 2'd0);
  assign bus.m_data  = w_head[DATA_SIZE-1:0];
  assign bus.m_last  = w_head[DATA_SIZE];
  assign rd_count    = r_rd_count;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a show-ahead FIFO model and stream monitor.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic        en;
  logic        flush;
  logic [15:0] rd_count;
  logic        busy;

  fifo_rd_stream_if #(.DATA_SIZE(8)) bus ();

  fifo_rd_stream #(
    .DATA_SIZE(8),
    .PKT_LEN  (4),
    .CNT_W    (16)
  ) dut (
    .r_clk   (clk),
    .rrst_n  (rrst_n),
    .en      (en),
    .bus     (bus),
    .rd_count(rd_count),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: show-ahead head, empty flag updates on the popping edge.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush)           rd_ptr <= wr_ptr;
    else if (bus.r_inc)  rd_ptr <= rd_ptr + 1;
  end

  assign bus.r_empty = (rd_ptr == wr_ptr);
  assign bus.r_data  = mem[rd_ptr[7:0]];

  int n_vec  = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int got_d[$];
  int got_l[$];
  int got_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      got_d.push_back(int'(bus.m_data));
      got_l.push_back(int'(bus.m_last));
      got_c.push_back(cyc);
    end
    if (bus.r_inc) pop_cnt++;
    if (bus.r_empty) check("no_pop_when_empty", 32'(bus.r_inc), 32'd0);
  end

  task automatic push_word(input int v);
    mem[wr_ptr[7:0]] = v[7:0];
    wr_ptr++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare delivered words from index base against first..first+n-1; last_mask bit i = last.
  task automatic check_words(input string tag, input int base, input int first, input int n,
                             input int last_mask);
    check({tag, "_count"}, 32'(got_d.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_d.size()) begin
        check({tag, "_data"}, 32'(got_d[base+i]), 32'(first + i));
        check({tag, "_last"}, 32'(got_l[base+i]), 32'((last_mask >> i) & 1));
      end
    end
  endtask

  int base;
  int p0;
  int t0;

  initial begin
    rrst_n = 1'b0;
    en = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b0;
    push_word(8'h01);

    // 1. Reset with data available and en=1
    step(2);
    check("rst_r_inc", 32'(bus.r_inc), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);
    en = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    rrst_n = 1'b1;
    step(1);

    // 2. Stream of 8 words at full rate
    for (int i = 0; i < 8; i++) push_word(8'h10 + i);
    base = got_d.size();
    bus.m_ready = 1'b1;
    en = 1'b1;
    t0 = cyc;
    step(12);
    check_words("stream", base, 8'h10, 8, 8'h88);
    for (int i = 0; i < 8; i++) begin
      if (base + i < got_c.size()) check("stream_cycle", 32'(got_c[base+i]), 32'(t0 + 1 + i));
    end
    check("stream_rd_count", 32'(rd_count), 32'd8);

    // 3. Backpressure: only two pops while m_ready=0
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h20 + i);
    base = got_d.size();
    p0 = pop_cnt;
    step(5);
    check("bp_pops", 32'(pop_cnt - p0), 32'd2);
    check("bp_r_inc", 32'(bus.r_inc), 32'd0);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check("bp_hold_data", 32'(bus.m_data), 32'h20);
    step(2);
    check("bp_hold_data2", 32'(bus.m_data), 32'h20);
    check("bp_hold_last", 32'(bus.m_last), 32'd0);
    bus.m_ready = 1'b1;
    step(8);
    check("bp_pops_total", 32'(pop_cnt - p0), 32'd5);
    check_words("bp", base, 8'h20, 5, 5'b01000);
    check("bp_rd_count", 32'(rd_count), 32'd13);

    // 4. Empty boundary: a single word, then the FIFO runs dry
    p0 = pop_cnt;
    base = got_d.size();
    push_word(8'h30);
    step(5);
    check("empty_pops", 32'(pop_cnt - p0), 32'd1);
    check("empty_m_valid", 32'(bus.m_valid), 32'd0);
    check_words("empty", base, 8'h30, 1, 0);
    check("empty_rd_count", 32'(rd_count), 32'd14);
    base = got_d.size();
    push_word(8'h31);
    step(4);
    check_words("single", base, 8'h31, 1, 0);

    // 5. Drain with two buffered words, then resume framing
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h40 + i);
    base = got_d.size();
    p0 = pop_cnt;
    step(3);
    check("drain_fill_pops", 32'(pop_cnt - p0), 32'd2);
    check("drain_fill_data", 32'(bus.m_data), 32'h40);
    en = 1'b0;
    bus.m_ready = 1'b1;
    step(1);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_state", 32'(dut.r_state), 32'(DRAIN));
    step(3);
    check("drain_idle_busy", 32'(busy), 32'd0);
    check("drain_m_valid", 32'(bus.m_valid), 32'd0);
    check("drain_no_pops", 32'(pop_cnt - p0), 32'd2);
    check_words("drain", base, 8'h40, 2, 2'b01);
    en = 1'b1;
    step(6);
    check_words("resume", base, 8'h40, 5, 5'b10001);
    check("resume_rd_count", 32'(rd_count), 32'd20);

    // 6. Reset mid-packet clears buffer and framing
    for (int i = 0; i < 2; i++) push_word(8'h50 + i);
    step(5);
    check("mid_rd_count", 32'(rd_count), 32'd22);
    bus.m_ready = 1'b0;
    push_word(8'h52);
    push_word(8'h53);
    step(4);
    check("mid_buffered", 32'(bus.m_data), 32'h52);
    rrst_n = 1'b0;
    flush = 1'b1;
    step(1);
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_rd_count", 32'(rd_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rrst_n = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h60 + i);
    base = got_d.size();
    bus.m_ready = 1'b1;
    step(8);
    check_words("post_rst", base, 8'h60, 4, 4'b1000);
    check("post_rst_rd_count", 32'(rd_count), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
